// File: rtl/sauria_pkg.sv
// sauria_pkg: shared constants and types for the SRAM C port arbiter slice.
//   ADRC_W / SRAMC_W / SRAMC_N  : SRAM C address width, word width, elements per word
//   OC_W                        : width of one write-mask element
//   SRAMC_RD_LAT                : default SRAM C read latency
//   SRAMC_STARVE_MAX            : default DMA starvation bound
//   sramc_req_t                 : one request (write flag, address, data, element mask)
//   arb_id_e                    : requester identity carried with a read
//   rd_tag_t                    : one read-tag pipe slot
package sauria_pkg;

    localparam int unsigned ADRC_W           = 12;
    localparam int unsigned SRAMC_W          = 128;
    localparam int unsigned SRAMC_N          = 4;
    localparam int unsigned OC_W             = SRAMC_W / SRAMC_N;
    localparam int unsigned SRAMC_RD_LAT     = 1;
    localparam int unsigned SRAMC_STARVE_MAX = 8;

    typedef struct packed {
        logic               we;
        logic [ADRC_W-1:0]  addr;
        logic [SRAMC_W-1:0] wdata;
        logic [SRAMC_N-1:0] wmask;
    } sramc_req_t;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_DMA  = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic    valid;
        arb_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/sramc_rd_tag_pipe.sv
// sramc_rd_tag_pipe: DEPTH-stage shift register of {valid, requester id} that
// follows each issued SRAM read until its data appears on the SRAM read port.
//   i_clk, i_rstn     : clock, asynchronous active-low reset (flushes all tags)
//   i_valid, i_id     : tag entering at the command register stage
//   o_valid, o_id     : tag leaving after DEPTH cycles
module sramc_rd_tag_pipe
    import sauria_pkg::*;
#(
    parameter int unsigned DEPTH = SRAMC_RD_LAT
) (
    input  logic    i_clk,
    input  logic    i_rstn,
    input  logic    i_valid,
    input  arb_id_e i_id,
    output logic    o_valid,
    output arb_id_e o_id
);

    rd_tag_t tag_q [DEPTH];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '{valid: 1'b0, id: ARB_CORE};
            end
        end else begin
            tag_q[0] <= '{valid: i_valid, id: i_id};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        o_valid = tag_q[DEPTH-1].valid;
        o_id    = tag_q[DEPTH-1].id;
    end

endmodule

// File: rtl/sramc_port_arbiter.sv
// sramc_port_arbiter: shares the single SRAM C port between the core psum
// manager and the DMA engine. Core has priority; a starvation counter forces a
// DMA grant after STARVE_MAX consecutive denied cycles. Read data is steered
// back to the issuing requester via a tag pipe.
//   i_clk, i_rstn                 : clock, asynchronous active-low reset
//   i_{core,dma}_req/we/addr/wdata/wmask : requests, held stable until granted
//   o_{core,dma}_gnt              : combinational grants (at most one)
//   o_{core,dma}_rvalid, o_rdata  : read response, one cycle per granted read
//   o_sram_en/we/addr/wdata/wmask : registered SRAM command
//   i_sram_rdata                  : SRAM read data, RD_LAT cycles after command
// Optional: define SRAMC_ARB_STATS_EN to add o_stat_conflicts and
// o_stat_starve_forced (32-bit saturating event counters).
module sramc_port_arbiter
    import sauria_pkg::*;
#(
    parameter int unsigned ADR_W      = ADRC_W,
    parameter int unsigned DAT_W      = SRAMC_W,
    parameter int unsigned NEL        = SRAMC_N,
    parameter int unsigned RD_LAT     = SRAMC_RD_LAT,
    parameter int unsigned STARVE_MAX = SRAMC_STARVE_MAX
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_core_req,
    input  logic             i_core_we,
    input  logic [ADR_W-1:0] i_core_addr,
    input  logic [DAT_W-1:0] i_core_wdata,
    input  logic [NEL-1:0]   i_core_wmask,
    input  logic             i_dma_req,
    input  logic             i_dma_we,
    input  logic [ADR_W-1:0] i_dma_addr,
    input  logic [DAT_W-1:0] i_dma_wdata,
    input  logic [NEL-1:0]   i_dma_wmask,
    output logic             o_core_gnt,
    output logic             o_dma_gnt,
    output logic             o_core_rvalid,
    output logic             o_dma_rvalid,
    output logic [DAT_W-1:0] o_rdata,
    output logic             o_sram_en,
    output logic             o_sram_we,
    output logic [ADR_W-1:0] o_sram_addr,
    output logic [DAT_W-1:0] o_sram_wdata,
    output logic [NEL-1:0]   o_sram_wmask,
    input  logic [DAT_W-1:0] i_sram_rdata
`ifdef SRAMC_ARB_STATS_EN
    ,
    output logic [31:0]      o_stat_conflicts,
    output logic [31:0]      o_stat_starve_forced
`endif
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    sramc_req_t       core_req_s;
    sramc_req_t       dma_req_s;
    sramc_req_t       sel_req_s;
    arb_id_e          sel_id;
    arb_id_e          cmd_id;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             dma_prio;
    logic             any_gnt;
    logic             tag_valid;
    arb_id_e          tag_id;

    // Requests travel through the package struct, which is sized for the
    // default SRAM C geometry; the casts are identity at default parameters.
    always_comb begin
        core_req_s = '{we:    i_core_we,
                       addr:  ADRC_W'(i_core_addr),
                       wdata: SRAMC_W'(i_core_wdata),
                       wmask: SRAMC_N'(i_core_wmask)};
        dma_req_s  = '{we:    i_dma_we,
                       addr:  ADRC_W'(i_dma_addr),
                       wdata: SRAMC_W'(i_dma_wdata),
                       wmask: SRAMC_N'(i_dma_wmask)};
    end

    // Arbitration and starvation tracking.
    always_comb begin
        dma_prio   = (starve_cnt == CNT_MAX);
        o_core_gnt = 1'b0;
        o_dma_gnt  = 1'b0;
        if (i_rstn) begin
            if (i_dma_req && (dma_prio || !i_core_req)) begin
                o_dma_gnt = 1'b1;
            end else if (i_core_req) begin
                o_core_gnt = 1'b1;
            end
        end
        any_gnt   = o_core_gnt | o_dma_gnt;
        sel_id    = o_dma_gnt ? ARB_DMA : ARB_CORE;
        sel_req_s = o_dma_gnt ? dma_req_s : core_req_s;

        starve_nxt = starve_cnt;
        if (!i_dma_req || o_dma_gnt) begin
            starve_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Registered SRAM command; fields hold when idle, only the enable drops.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sram_en    <= 1'b0;
            o_sram_we    <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_wmask <= '0;
            cmd_id       <= ARB_CORE;
            starve_cnt   <= '0;
        end else begin
            o_sram_en  <= any_gnt;
            starve_cnt <= starve_nxt;
            if (any_gnt) begin
                o_sram_we    <= sel_req_s.we;
                o_sram_addr  <= ADR_W'(sel_req_s.addr);
                o_sram_wdata <= DAT_W'(sel_req_s.wdata);
                o_sram_wmask <= NEL'(sel_req_s.wmask);
                cmd_id       <= sel_id;
            end
        end
    end

    // The tag enters alongside the registered command, so after RD_LAT more
    // edges it lines up with the SRAM read data.
    sramc_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (o_sram_en & ~o_sram_we),
        .i_id    (cmd_id),
        .o_valid (tag_valid),
        .o_id    (tag_id)
    );

    always_comb begin
        o_core_rvalid = tag_valid && (tag_id == ARB_CORE);
        o_dma_rvalid  = tag_valid && (tag_id == ARB_DMA);
        o_rdata       = tag_valid ? i_sram_rdata : '0;
    end

`ifdef SRAMC_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_stat_conflicts     <= '0;
            o_stat_starve_forced <= '0;
        end else begin
            if (i_core_req && i_dma_req && (o_stat_conflicts != '1)) begin
                o_stat_conflicts <= o_stat_conflicts + 32'd1;
            end
            if (o_dma_gnt && dma_prio && (o_stat_starve_forced != '1)) begin
                o_stat_starve_forced <= o_stat_starve_forced + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sramc_port_arbiter.sv
// tb_sramc_port_arbiter: directed bench for sramc_port_arbiter (RD_LAT=2,
// STARVE_MAX=8) with a behavioural SRAM, a reference model and literal checks.
module tb_sramc_port_arbiter;

    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 128;
    localparam int unsigned NE   = 4;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [NE-1:0] core_wmask = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic [NE-1:0] dma_wmask = '0;
    logic          core_gnt, dma_gnt, core_rvalid, dma_rvalid;
    logic [DW-1:0] rdata;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [NE-1:0] sram_wmask;
    logic [DW-1:0] sram_rdata;
`ifdef SRAMC_ARB_STATS_EN
    logic [31:0]   stat_conf, stat_forced;
`endif

    sramc_port_arbiter #(
        .ADR_W(AW), .DAT_W(DW), .NEL(NE), .RD_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .i_core_wmask(core_wmask),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
        .i_dma_wdata(dma_wdata), .i_dma_wmask(dma_wmask),
        .o_core_gnt(core_gnt), .o_dma_gnt(dma_gnt),
        .o_core_rvalid(core_rvalid), .o_dma_rvalid(dma_rvalid), .o_rdata(rdata),
        .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .o_sram_wmask(sram_wmask),
        .i_sram_rdata(sram_rdata)
`ifdef SRAMC_ARB_STATS_EN
        , .o_stat_conflicts(stat_conf), .o_stat_starve_forced(stat_forced)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b", n, a, e);
        end
    endtask

    task automatic checkw(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, a, e);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        if (a == 32'h010) return {16{8'hA5}};
        if (a == 32'h020) return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        return {32'(a) + 32'h4000_0000, 32'(a) + 32'h3000_0000,
                32'(a) + 32'h2000_0000, 32'(a) + 32'h1000_0000};
    endfunction

    // Behavioural SRAM: command sampled at the edge after it is presented,
    // read data then appears LAT edges after the command edge.
    logic [DW-1:0] sram_mem  [0:4095];
    logic [DW-1:0] model_mem [0:4095];
    logic [DW-1:0] rd_pipe   [LAT];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sram_mem[i]  = init_word(i);
            model_mem[i] = init_word(i);
        end
    end

    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            for (int e = 0; e < NE; e++) begin
                if (sram_wmask[e]) sram_mem[sram_addr][e*32 +: 32] <= sram_wdata[e*32 +: 32];
            end
        end
        rd_pipe[0] <= (sram_en && !sram_we) ? sram_mem[sram_addr] : {4{32'hDEADBEEF}};
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    // Reference model state.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int unsigned due; logic id; logic [DW-1:0] data; } resp_t;
    typedef struct { int unsigned c;   logic id; logic [DW-1:0] data; } ev_t;
    resp_t rq[$];
    ev_t   log_q[$];
    int    denied = 0;
    logic          exp_en = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [NE-1:0] exp_wmask = '0;

    always @(negedge clk) begin
        logic          ec, ed, pri, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [NE-1:0] wm;
        if (!rstn) begin
            check1("rst core_gnt", core_gnt, 1'b0);
            check1("rst dma_gnt", dma_gnt, 1'b0);
            check1("rst core_rvalid", core_rvalid, 1'b0);
            check1("rst dma_rvalid", dma_rvalid, 1'b0);
            check1("rst sram_en", sram_en, 1'b0);
            check1("rst sram_we", sram_we, 1'b0);
            checkw("rst sram_addr", DW'(sram_addr), '0);
            checkw("rst sram_wdata", sram_wdata, '0);
            checkw("rst sram_wmask", DW'(sram_wmask), '0);
            checkw("rst rdata", rdata, '0);
            rq.delete();
            denied = 0;
            exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
        end else begin
            check1("sram_en", sram_en, exp_en);
            check1("sram_we", sram_we, exp_we);
            checkw("sram_addr", DW'(sram_addr), DW'(exp_addr));
            checkw("sram_wdata", sram_wdata, exp_wdata);
            checkw("sram_wmask", DW'(sram_wmask), DW'(exp_wmask));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                check1("core_rvalid", core_rvalid, !rq[0].id);
                check1("dma_rvalid", dma_rvalid, rq[0].id);
                checkw("rdata", rdata, rq[0].data);
                void'(rq.pop_front());
            end else begin
                check1("core_rvalid idle", core_rvalid, 1'b0);
                check1("dma_rvalid idle", dma_rvalid, 1'b0);
            end
            // DMA wins only when it has been refused SMAX cycles in a row.
            pri = (denied >= int'(SMAX));
            ec  = core_req && !(dma_req && pri);
            ed  = dma_req && !ec;
            check1("core_gnt", core_gnt, ec);
            check1("dma_gnt", dma_gnt, ed);
            if (!dma_req || ed) denied = 0;
            else denied++;
            exp_en = ec || ed;
            if (ec || ed) begin
                we = ed ? dma_we : core_we;
                a  = ed ? dma_addr : core_addr;
                wd = ed ? dma_wdata : core_wdata;
                wm = ed ? dma_wmask : core_wmask;
                exp_we = we; exp_addr = a; exp_wdata = wd; exp_wmask = wm;
                if (we) begin
                    for (int e = 0; e < NE; e++)
                        if (wm[e]) model_mem[a][e*32 +: 32] = wd[e*32 +: 32];
                end else begin
                    rq.push_back('{due: cyc + 1 + LAT, id: ed, data: model_mem[a]});
                end
            end
        end
        if (core_rvalid || dma_rvalid) log_q.push_back('{c: cyc, id: dma_rvalid, data: rdata});
    end

    task automatic expect_ev(input string n, input int unsigned c, input logic id, input logic [DW-1:0] d);
        int idx = -1;
        foreach (log_q[i]) if (log_q[i].c == c) idx = i;
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no read response in cycle %0d, required one", n, c);
        end else begin
            check1({n, " id"}, log_q[idx].id, id);
            checkw({n, " data"}, log_q[idx].data, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic r, input logic w, input int unsigned a,
                            input logic [DW-1:0] d, input logic [NE-1:0] m);
        core_req = r; core_we = w; core_addr = AW'(a); core_wdata = d; core_wmask = m;
    endtask

    task automatic set_dma(input logic r, input logic w, input int unsigned a,
                           input logic [DW-1:0] d, input logic [NE-1:0] m);
        dma_req = r; dma_we = w; dma_addr = AW'(a); dma_wdata = d; dma_wmask = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned g, g0;
        int unsigned ge[8];
        int          cnt;
        logic        dsel;
`ifdef SRAMC_ARB_STATS_EN
        logic [31:0] base_c, base_f;
`endif
        // Reset state, checked by the model process every cycle.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Core-only read of 0x010.
        tick();
        set_core(1, 0, 'h010, '0, '0);
        @(negedge clk);
        check1("B core_gnt", core_gnt, 1'b1);
        check1("B dma_gnt", dma_gnt, 1'b0);
        g = cyc;
        tick();
        set_core(0, 0, 0, '0, '0);
        @(negedge clk);
        check1("B sram_en", sram_en, 1'b1);
        checkw("B sram_addr", DW'(sram_addr), DW'(12'h010));
        repeat (LAT + 3) @(negedge clk);
        expect_ev("B resp", g + 1 + LAT, 1'b0, {16{8'hA5}});

        // Both requesters hold reads: 8 core grants then 1 DMA grant, repeating.
        tick();
        set_core(1, 0, 'h100, '0, '0);
        set_dma(1, 0, 'h200, '0, '0);
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            dsel = ((i % 9) == 8);
            check1($sformatf("C dma_gnt %0d", i), dma_gnt, dsel);
            check1($sformatf("C core_gnt %0d", i), core_gnt, !dsel);
            tick();
        end

        // Core masked write to 0x020 followed by a DMA read of the same word.
        set_core(1, 1, 'h020, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 4'b0101);
        set_dma(0, 0, 0, '0, '0);
        @(negedge clk);
        check1("D core_gnt", core_gnt, 1'b1);
        tick();
        set_core(0, 0, 0, '0, '0);
        set_dma(1, 0, 'h020, '0, '0);
        @(negedge clk);
        check1("D dma_gnt", dma_gnt, 1'b1);
        g = cyc;
        tick();
        set_dma(0, 0, 0, '0, '0);
        repeat (LAT + 3) @(negedge clk);
        expect_ev("D merged", g + 1 + LAT, 1'b1,
                  {32'h44444444, 32'hCCCCCCCC, 32'h22222222, 32'hAAAAAAAA});

        // Alternating single-requester reads, one grant per cycle.
        tick();
        for (int k = 0; k < 8; k++) begin
            set_core((k % 2) == 0, 0, 'h300 + k, '0, '0);
            set_dma((k % 2) == 1, 0, 'h300 + k, '0, '0);
            @(negedge clk);
            check1($sformatf("E gnt %0d", k), (k % 2 == 1) ? dma_gnt : core_gnt, 1'b1);
            ge[k] = cyc;
            tick();
        end
        set_core(0, 0, 0, '0, '0);
        set_dma(0, 0, 0, '0, '0);
        repeat (LAT + 3) @(negedge clk);
        for (int k = 0; k < 8; k++)
            expect_ev($sformatf("E resp %0d", k), ge[0] + 1 + LAT + k, (k % 2) == 1, init_word('h300 + k));

        // Reset with two reads in flight.
        tick();
        set_core(1, 0, 'h040, '0, '0);
        @(negedge clk);
        g0 = cyc;
        tick();
        set_core(0, 0, 0, '0, '0);
        set_dma(1, 0, 'h041, '0, '0);
        @(negedge clk);
        @(posedge clk);
        set_dma(0, 0, 0, '0, '0);
        set_core(1, 0, 'h043, '0, '0);
        #2 rstn = 1'b0;
        #1;
        check1("F async sram_en", sram_en, 1'b0);
        checkw("F async sram_addr", DW'(sram_addr), '0);
        check1("F gnt forced", core_gnt, 1'b0);
        repeat (3) @(negedge clk);
        set_core(0, 0, 0, '0, '0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        cnt = 0;
        foreach (log_q[i]) if (log_q[i].c > g0) cnt++;
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL F flushed: got %0d responses after reset, required 0", cnt);
        end
        tick();
        set_core(1, 0, 'h042, '0, '0);
        @(negedge clk);
        g = cyc;
        tick();
        set_core(0, 0, 0, '0, '0);
        repeat (LAT + 3) @(negedge clk);
        expect_ev("F new read", g + 1 + LAT, 1'b0, init_word('h042));

`ifdef SRAMC_ARB_STATS_EN
        @(negedge clk);
        base_c = stat_conf;
        base_f = stat_forced;
        tick();
        set_core(1, 0, 'h500, '0, '0);
        set_dma(1, 0, 'h600, '0, '0);
        repeat (20) @(posedge clk);
        #1;
        set_core(0, 0, 0, '0, '0);
        set_dma(0, 0, 0, '0, '0);
        @(negedge clk);
        checkw("S conflicts", DW'(stat_conf - base_c), DW'(32'd20));
        checkw("S forced", DW'(stat_forced - base_f), DW'(32'd2));
`endif

        repeat (LAT + 5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
